uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive side of the SoC UART: samples the uart_in pin, deframes 8N1 characters
//   using 16x oversampling and buffers them in a small FIFO.
//   The bus-slave register front end pops bytes from the FIFO and reads the error flags.
//   Sits between the external uart_in pad and the UART bus registers.
//   rx_int_o feeds one of the CPU interrupt inputs.
// PARAMETERS
//   OS_DIV     27  clk cycles per oversample tick (50 MHz / (115200*16) = 27)
//   FIFO_DEPTH 8   receive FIFO entries; power of 2, >= 2
// PORTS
//   clk            in   1  system clock; all logic on rising edge
//   rst            in   1  synchronous, active-high reset
//   uart_in        in   1  asynchronous serial input, idle high
//   rd_en_i        in   1  pop request from bus front end
//   rd_data_o      out  8  FIFO head byte (show-ahead); valid when rx_valid_o=1
//   rx_valid_o     out  1  FIFO non-empty
//   fifo_count_o   out  log2(FIFO_DEPTH)+1  number of stored bytes
//   overrun_o      out  1  sticky: byte dropped because FIFO full
//   frame_err_o    out  1  sticky: stop bit sampled low
//   clr_err_i      in   1  clears both sticky flags
//   rx_int_o       out  1  interrupt level = rx_valid_o | overrun_o | frame_err_o
// BEHAVIOUR
//   Reset
//     all outputs 0; sync flops = 1; FSM = IDLE; armed = 0; FIFO empty.
//   Input sync
//     2-flop synchronizer on uart_in; everything below uses the synced value rxs.
//   Tick generator
//     counter 0..OS_DIV-1, free-running; tick=1 for one clk when counter==OS_DIV-1.
//   Arming
//     after reset, IDLE ignores low until rxs has been sampled high on one tick.
//     This discards a frame already in progress when reset drops.
//   FSM (advances only on tick; sample counter sc 0..15)
//     IDLE:  armed & rxs==0 -> START, sc=0.
//     START: at sc==7 (mid-bit): rxs==0 -> DATA, sc=0, bit=0; rxs==1 -> IDLE (glitch rejected).
//     DATA:  at sc==15 shift rxs into shreg, LSB first; bit 7 done -> STOP, sc=0.
//     STOP:  at sc==15: rxs==1 -> push shreg; rxs==0 -> set frame_err_o, discard byte;
//            either way -> IDLE.
//     Effective sampling point of every bit is its midpoint.
//   Latency
//     the byte appears at rd_data_o and rx_valid_o rises 1 clk after the stop-bit sample tick.
//   FIFO
//     circular buffer with wrapping rd/wr pointers; count is held separately.
//     pop when rd_en_i & count!=0; rd_en_i while empty is ignored.
//     push while full and no pop: byte dropped, overrun_o set.
//     push and pop in same clk while full: both happen, no overrun, count unchanged.
//     push and pop in same clk while empty: pop ignored, push accepted, count=1.
//   Sticky flags
//     set by their event and held until clr_err_i.
//     set and clr_err_i in same clk: set wins.
//   Reset mid-frame
//     FSM, shreg, FIFO and flags return to reset values; no partial byte is ever pushed.
// STRUCTURE
//   Shared package/include
//     FSM state encodings (IDLE/START/DATA/STOP, 2 bits), UART_DW=8, OS_RATE=16, SAMPLE_MID=7.
//   Sub-module sync_fifo #(DW, DEPTH)
//     ports: push/pop/din/dout/count/full/empty; reusable by uart_tx.
//   Top level holds: synchronizer, tick generator, FSM/shift register, flag logic.
// TESTING (bench uses OS_DIV=4 -> 64 clk per bit)
//   - Frame 0xA5, 8N1
//       -> rd_data_o=0xA5, rx_valid_o=1, count=1, rx_int_o=1;
//          pop -> count=0, rx_valid_o=0.
//   - Low glitch of 20 clk on idle line
//       -> no push, FSM back in IDLE, flags 0.
//   - Frame 0x3C with stop bit low
//       -> frame_err_o=1, count unchanged;
//          clr_err_i pulse -> frame_err_o=0.
//   - 9 back-to-back frames 0x01..0x09, no pops
//       -> count=8, overrun_o=1, pops return 0x01..0x08 in order.
//   - FIFO full, rd_en_i held during 9th stop-bit sample
//       -> overrun_o=0, count stays 8, head advances to 0x02.
//   - rst asserted mid-DATA of frame 0x55, released, then frame 0x81 sent
//       -> only 0x81 received, count=1.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: character geometry, oversampling
// constants and the deframer state encoding.
package uart_rx_fifo_pkg;

  localparam int UART_DW    = 8;
  localparam int OS_RATE    = 16;
  localparam int SAMPLE_MID = 7;
  localparam int SC_W       = $clog2(OS_RATE);
  localparam int BIT_W      = $clog2(UART_DW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Register-side view of the UART receiver: FIFO pop, head byte, fill level,
// sticky error flags and the interrupt level.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) ();

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic               rd_en_i;
  logic [UART_DW-1:0] rd_data_o;
  logic               rx_valid_o;
  logic [CW-1:0]      fifo_count_o;
  logic               overrun_o;
  logic               frame_err_o;
  logic               clr_err_i;
  logic               rx_int_o;

  modport master (
    output rd_en_i, clr_err_i,
    input  rd_data_o, rx_valid_o, fifo_count_o, overrun_o, frame_err_o, rx_int_o
  );

  modport slave (
    input  rd_en_i, clr_err_i,
    output rd_data_o, rx_valid_o, fifo_count_o, overrun_o, frame_err_o, rx_int_o
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock circular FIFO with show-ahead output; a pop and a push in the same
// cycle are both honoured when full, and a pop is ignored when empty.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          push_eff;
  logic          pop_eff;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);

  always_comb begin
    count_next = count_reg;
    case ({push_eff, pop_eff})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage is not reset; the output is forced to zero while nothing valid is held.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, input synchronizer, receive FIFO,
// sticky overrun/framing flags and a level interrupt.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int OS_DIV     = 27,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_in,
  uart_rx_fifo_if.slave  bus
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  logic               rx_meta_reg;
  logic               rxs_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic               tick;
  logic               armed_reg;
  rx_state_e          state_reg, state_next;
  logic [SC_W-1:0]    sc_reg, sc_next;
  logic [BIT_W-1:0]   bit_reg, bit_next;
  logic [UART_DW-1:0] shreg_reg, shreg_next;
  logic               push;
  logic               frame_err_set;
  logic               overrun_set;
  logic               pop;
  logic               overrun_reg;
  logic               frame_err_reg;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [UART_DW-1:0] fifo_dout;

  assign tick = (div_cnt_reg == DIV_W'(OS_DIV - 1));

  // Synchronizer, oversample divider and the arm latch that skips a frame already
  // in progress when reset drops (the line must be seen idle on a tick first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
      div_cnt_reg <= '0;
      armed_reg   <= 1'b0;
    end else begin
      rx_meta_reg <= uart_in;
      rxs_reg     <= rx_meta_reg;
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      armed_reg   <= armed_reg | (tick & rxs_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sc_reg    <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      sc_reg    <= sc_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
    end
  end

  // Start is confirmed half a bit after the falling edge; every later sample is a
  // full bit period on, which lands each one at its bit midpoint.
  always_comb begin
    state_next    = state_reg;
    sc_next       = sc_reg;
    bit_next      = bit_reg;
    shreg_next    = shreg_reg;
    push          = 1'b0;
    frame_err_set = 1'b0;
    if (tick) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (armed_reg && !rxs_reg) begin
            state_next = ST_START;
            sc_next    = '0;
          end
        end
        ST_START: begin
          if (sc_reg == SC_W'(SAMPLE_MID)) begin
            sc_next    = '0;
            bit_next   = '0;
            state_next = rxs_reg ? ST_IDLE : ST_DATA;
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (sc_reg == SC_W'(OS_RATE - 1)) begin
            sc_next    = '0;
            shreg_next = {rxs_reg, shreg_reg[UART_DW-1:1]};
            if (bit_reg == BIT_W'(UART_DW - 1)) state_next = ST_STOP;
            else                                bit_next   = bit_reg + 1'b1;
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (sc_reg == SC_W'(OS_RATE - 1)) begin
            sc_next       = '0;
            push          = rxs_reg;
            frame_err_set = ~rxs_reg;
            state_next    = ST_IDLE;
          end else begin
            sc_next = sc_reg + 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DW    (UART_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.rd_en_i),
    .din   (shreg_reg),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A simultaneous pop makes room, so only an unmatched push into a full FIFO drops.
  assign pop         = bus.rd_en_i & ~fifo_empty;
  assign overrun_set = push & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      overrun_reg   <= overrun_set   | (overrun_reg   & ~bus.clr_err_i);
      frame_err_reg <= frame_err_set | (frame_err_reg & ~bus.clr_err_i);
    end
  end

  assign bus.rd_data_o    = fifo_dout;
  assign bus.rx_valid_o   = ~fifo_empty;
  assign bus.fifo_count_o = fifo_count;
  assign bus.overrun_o    = overrun_reg;
  assign bus.frame_err_o  = frame_err_reg;
  assign bus.rx_int_o     = ~fifo_empty | overrun_reg | frame_err_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are driven on uart_in, expected bytes are
// queued at stimulus time and a negedge monitor checks every accepted pop.
module tb_uart_rx_fifo;

  localparam int OS_DIV = 4;
  localparam int DEPTH  = 8;
  localparam int BITCLK = OS_DIV * 16;

  logic clk = 1'b0;
  logic rst;
  logic uart_in;
  int   cyc;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .OS_DIV     (OS_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_in (uart_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop is compared against the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && bus.rd_en_i && bus.rx_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got %02h, expected no data", bus.rd_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("pop: data=%02h expected=%02h", bus.rd_data_o, e);
        check("pop_data", {24'd0, bus.rd_data_o}, {24'd0, e});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    @(posedge clk); #1 bus.rd_en_i = 1'b1;
    @(posedge clk); #1 bus.rd_en_i = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 bus.clr_err_i = 1'b1;
    @(posedge clk); #1 bus.clr_err_i = 1'b0;
  endtask

  // Start edge is aligned so the stop-bit sample lands exactly 611 clk after it;
  // with pop_at_push the pop is issued on that very cycle.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic pop_at_push);
    while (cyc % OS_DIV != 1) begin
      @(posedge clk); #1;
    end
    $display("frame: data=%02h stop=%0d pop_at_push=%0d", data, stop, pop_at_push);
    uart_in = 1'b0;
    idle(BITCLK);
    for (int i = 0; i < 8; i++) begin
      uart_in = data[i];
      idle(BITCLK);
    end
    uart_in = stop;
    if (pop_at_push) begin
      idle(34);
      bus.rd_en_i = 1'b1;
      idle(1);
      bus.rd_en_i = 1'b0;
      idle(29);
    end else begin
      idle(BITCLK);
    end
    uart_in = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] frame;
    rst           = 1'b1;
    uart_in       = 1'b1;
    bus.rd_en_i   = 1'b0;
    bus.clr_err_i = 1'b0;
    idle(5);
    check("rst_valid",     bus.rx_valid_o,   0);
    check("rst_count",     bus.fifo_count_o, 0);
    check("rst_data",      bus.rd_data_o,    0);
    check("rst_overrun",   bus.overrun_o,    0);
    check("rst_frame_err", bus.frame_err_o,  0);
    check("rst_int",       bus.rx_int_o,     0);
    rst = 1'b0;
    idle(20);

    // Single frame, then pop; a pop on an empty FIFO must be ignored.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_data",  bus.rd_data_o,    8'hA5);
    check("a5_valid", bus.rx_valid_o,   1);
    check("a5_count", bus.fifo_count_o, 1);
    check("a5_int",   bus.rx_int_o,     1);
    pop_one();
    check("a5_count_after_pop", bus.fifo_count_o, 0);
    check("a5_valid_after_pop", bus.rx_valid_o,   0);
    pop_one();
    check("empty_pop_count", bus.fifo_count_o, 0);

    // Short low glitch on an idle line.
    uart_in = 1'b0;
    idle(20);
    uart_in = 1'b1;
    idle(200);
    check("glitch_count",     bus.fifo_count_o, 0);
    check("glitch_frame_err", bus.frame_err_o,  0);
    check("glitch_overrun",   bus.overrun_o,    0);

    // Framing error.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_flag", bus.frame_err_o, 1);
    check("ferr_int",  bus.rx_int_o,    1);
    idle(100);
    check("ferr_count", bus.fifo_count_o, 0);
    clr_pulse();
    check("ferr_cleared", bus.frame_err_o, 0);

    // Nine frames without popping: the ninth is dropped.
    for (int b = 1; b <= 9; b++) begin
      if (b <= 8) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 1'b0);
    end
    check("ovr_count", bus.fifo_count_o, 8);
    check("ovr_flag",  bus.overrun_o,    1);
    for (int k = 0; k < 8; k++) pop_one();
    check("ovr_drained", bus.fifo_count_o, 0);
    clr_pulse();
    check("ovr_cleared", bus.overrun_o, 0);

    // Full FIFO with a pop on the push cycle of the ninth frame.
    for (int b = 1; b <= 8; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 1'b0);
    end
    check("full_count", bus.fifo_count_o, 8);
    exp_q.push_back(8'h09);
    send_frame(8'h09, 1'b1, 1'b1);
    check("pp_overrun", bus.overrun_o,    0);
    check("pp_count",   bus.fifo_count_o, 8);
    check("pp_head",    bus.rd_data_o,    8'h02);
    for (int k = 0; k < 8; k++) pop_one();
    check("pp_drained", bus.fifo_count_o, 0);
    check("pp_queue_empty", exp_q.size(), 0);

    // Reset during DATA of 0x55, released while the line is still low in bit 7.
    send_frame(8'h7E, 1'b1, 1'b0);
    check("pre_rst_count", bus.fifo_count_o, 1);
    frame = 8'h55;
    while (cyc % OS_DIV != 1) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      uart_in = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : frame[i-1]);
      for (int c = 0; c < BITCLK; c++) begin
        if (i == 5 && c == 20) begin
          rst = 1'b1;
          exp_q.delete();
        end
        if (i == 7 && c == 0) begin
          check("in_rst_count", bus.fifo_count_o, 0);
          check("in_rst_valid", bus.rx_valid_o,   0);
          check("in_rst_data",  bus.rd_data_o,    0);
        end
        if (i == 8 && c == 8) rst = 1'b0;
        idle(1);
      end
    end
    uart_in = 1'b1;
    idle(700);
    check("post_rst_count",     bus.fifo_count_o, 0);
    check("post_rst_frame_err", bus.frame_err_o,  0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    check("r81_count", bus.fifo_count_o, 1);
    check("r81_data",  bus.rd_data_o,    8'h81);
    pop_one();
    check("r81_queue_empty", exp_q.size(), 0);

    idle(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
